bram_port_ctrl: RTL and testbench

Request-side controller for one port of the team's true-dual-port block RAM, which has a fixed 2-cycle registered read latency. Converts a valid/ready request stream (read or write) into registered BRAM port signals, tracks in-flight reads, and returns read data on a backpressured valid/ready response stream. It also provides a hardware fill sequencer that writes a constant to every address. It sits between MobileNet weight/feature loaders and the BRAM, one instance per BRAM port.

---
 rtl/bram_pkg.sv | 20 ++
 rtl/bram_rsp_fifo.sv | 62 ++++++
 rtl/bram_port_ctrl.sv | 161 ++++++++++++++++
 tb/tb_bram_port_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared types and defaults for the block-RAM port controller.
// The response FIFO depth is always derived from the read latency.
package bram_pkg;

    localparam int DW_DEF  = 36;
    localparam int AW_DEF  = 12;
    localparam int LAT_DEF = 2;
    localparam int RD      = LAT_DEF + 2;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_INIT = 1'b1
    } state_e;

    // LAT+1 reads can be in flight at once, plus one slot of margin.
    function automatic int rsp_depth(input int lat);
        return lat + 2;
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// First-word-fall-through response FIFO for returning BRAM read data.
// The head word is presented combinationally whenever the FIFO is not empty.
module bram_rsp_fifo #(
    parameter  int DW    = 36,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clkA,
    input  logic          rstB,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(push_i) - CW'(do_pop);
    end

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clkA) begin
        if (rstB) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; empty masks stale words, keeping this plain RAM.
    always_ff @(posedge clkA) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/bram_port_ctrl.sv
// Request-side controller for one port of a fixed-latency true-dual-port BRAM.
// Issues registered port cycles, tracks reads in flight and runs a constant fill.
module bram_port_ctrl
    import bram_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic          clkA,
    input  logic          rstB,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    input  logic          init_start,
    input  logic [DW-1:0] init_value,
    output logic          init_done,
    output logic          busy,
    output logic          bram_en,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_din,
    input  logic [DW-1:0] bram_dout
);

    localparam int RD_DEPTH = rsp_depth(LAT);
    localparam int CW       = $clog2(RD_DEPTH + 1);
    localparam int SW       = CW + 1;

    state_e        state_q, state_d;
    logic [AW-1:0] fill_cnt_q, fill_cnt_d;
    logic [DW-1:0] fill_val_q, fill_val_d;
    logic          fill_last_q, fill_last_d;
    logic          init_done_q;
    logic          bram_en_q, bram_en_d;
    logic          bram_we_q, bram_we_d;
    logic [AW-1:0] bram_addr_q, bram_addr_d;
    logic [DW-1:0] bram_din_q, bram_din_d;
    logic [LAT-1:0] rd_pipe_q, rd_pipe_d;

    logic          in_run;
    logic          rd_issue;
    logic          rd_credit;
    logic          accept;
    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;

    assign in_run   = (state_q == ST_RUN);
    assign rd_issue = bram_en_q && !bram_we_q;

    always_comb begin
        inflight = CW'(rd_issue);
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(rd_pipe_q[i]);
        end
    end

    // A pop in the same cycle is deliberately not credited back.
    assign rd_credit = (SW'(inflight) + SW'(fifo_count)) < SW'(RD_DEPTH);
    assign req_ready = !rstB && in_run && !init_start && (req_we || rd_credit);
    assign accept    = req_valid && req_ready;

    always_comb begin
        rd_pipe_d[0] = rd_issue;
        for (int i = 1; i < LAT; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        fill_val_d  = fill_val_q;
        fill_last_d = 1'b0;
        bram_en_d   = 1'b0;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        case (state_q)
            ST_RUN: begin
                if (init_start) begin
                    state_d    = ST_INIT;
                    fill_cnt_d = '0;
                    fill_val_d = init_value;
                end else if (accept) begin
                    bram_en_d   = 1'b1;
                    bram_we_d   = req_we;
                    bram_addr_d = req_addr;
                    bram_din_d  = req_wdata;
                end
            end
            ST_INIT: begin
                bram_en_d   = 1'b1;
                bram_we_d   = 1'b1;
                bram_addr_d = fill_cnt_q;
                bram_din_d  = fill_val_q;
                if (fill_cnt_q == {AW{1'b1}}) begin
                    state_d     = ST_RUN;
                    fill_last_d = 1'b1;
                end else begin
                    fill_cnt_d = fill_cnt_q + AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clkA) begin
        if (rstB) begin
            state_q     <= ST_RUN;
            fill_cnt_q  <= '0;
            fill_val_q  <= '0;
            fill_last_q <= 1'b0;
            init_done_q <= 1'b0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            rd_pipe_q   <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_val_q  <= fill_val_d;
            fill_last_q <= fill_last_d;
            init_done_q <= fill_last_q;
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            rd_pipe_q   <= rd_pipe_d;
        end
    end

    bram_rsp_fifo #(
        .DW    (DW),
        .DEPTH (RD_DEPTH)
    ) u_rsp_fifo (
        .clkA        (clkA),
        .rstB        (rstB),
        .push_i      (rd_pipe_q[LAT-1]),
        .push_data_i (bram_dout),
        .pop_i       (rsp_ready),
        .head_o      (rsp_rdata),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign busy      = !in_run || (inflight != '0) || !fifo_empty;
    assign init_done = init_done_q;
    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Self-checking bench for bram_port_ctrl with a 2-cycle BRAM model and a
// memory/queue reference model of expected read responses.
module tb_bram_port_ctrl;

    localparam int DW  = 36;
    localparam int AW  = 4;
    localparam int LAT = 2;
    localparam int NW  = 2 ** AW;

    logic          clkA = 1'b0;
    logic          rstB;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_start, init_done, busy;
    logic [DW-1:0] init_value;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din, bram_dout;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_rsp  = 0;
    int nxt    = 0;
    int base   = 0;

    always #5 clkA = ~clkA;

    bram_port_ctrl #(.DW(DW), .AW(AW), .LAT(LAT)) dut (
        .clkA       (clkA),
        .rstB       (rstB),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .init_start (init_start),
        .init_value (init_value),
        .init_done  (init_done),
        .busy       (busy),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout)
    );

    // BRAM: address sampled on the enable edge, data out two edges later.
    logic [DW-1:0] bmem [NW];
    logic [DW-1:0] bstage;
    always @(posedge clkA) begin
        if (bram_en) begin
            if (bram_we) bmem[bram_addr] <= bram_din;
            else         bstage          <= bmem[bram_addr];
        end
        bram_dout <= bstage;
    end

    // Reference model: memory contents as seen by requests, plus ordered expected reads.
    logic [DW-1:0] ref_mem [NW];
    logic [DW-1:0] exp_q [$];
    int            fill_left = 0;

    initial begin
        for (int i = 0; i < NW; i++) begin
            bmem[i]    = 36'hC00000000 + DW'(i);
            ref_mem[i] = 36'hC00000000 + DW'(i);
        end
        bstage    = '0;
        bram_dout = '0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clkA) begin
        if (rstB) begin
            exp_q.delete();
            fill_left = 0;
        end else begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) check("rsp_spurious", rsp_valid, 1'b0);
                else                   check("rsp_rdata", rsp_rdata, exp_q[0]);
            end
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                n_rsp++;
            end
            if (fill_left > 0) begin
                fill_left--;
            end else if (init_start) begin
                for (int i = 0; i < NW; i++) ref_mem[i] = init_value;
                fill_left = NW - 1;
            end
            if (req_valid && req_ready) begin
                if (req_we) ref_mem[req_addr] = req_wdata;
                else        exp_q.push_back(ref_mem[req_addr]);
            end
        end
    end

    task automatic step();
        @(posedge clkA);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clkA);
    endtask

    // Called right after the accepting edge; response due LAT+1 cycles later.
    task automatic wait_rsp(input string name, input logic [DW-1:0] exp_lit);
        int c;
        for (c = 0; c < 40; c++) begin
            at_neg();
            if (rsp_valid) break;
            step();
        end
        check({name, "_lat"}, 64'(c), 64'(LAT + 1));
        check({name, "_data"}, rsp_rdata, exp_lit);
        step();
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp_lit);
        int c;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        for (c = 0; c < 40; c++) begin
            at_neg();
            if (req_ready) break;
            step();
        end
        check({name, "_acc"}, 64'(c < 40), 64'd1);
        step();
        req_valid = 1'b0;
        wait_rsp(name, exp_lit);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstB       = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        init_start = 1'b0;
        init_value = '0;

        // Reset values
        repeat (3) @(posedge clkA);
        at_neg();
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_bram", {bram_en, bram_we, bram_addr, bram_din}, '0);
        step();
        rstB = 1'b0;
        at_neg();
        check("post_rst_ready", req_ready, 1'b1);

        // Write 0x9ABCD1234 to 5, then read it back
        step();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'h5;
        req_wdata = 36'h9ABCD1234;
        at_neg();
        check("wr_ready", req_ready, 1'b1);
        step();
        req_we = 1'b0;
        at_neg();
        check("wr_port", {bram_en, bram_we, bram_addr, bram_din}, {2'b11, 4'h5, 36'h9ABCD1234});
        check("rd_ready", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        at_neg();
        check("rd_port", {bram_en, bram_we, bram_addr}, {2'b10, 4'h5});
        check("rd_lat0", rsp_valid, 1'b0);
        step(); at_neg();
        check("rd_idle_en", bram_en, 1'b0);
        check("rd_lat1", rsp_valid, 1'b0);
        step(); at_neg();
        check("rd_lat2", rsp_valid, 1'b0);
        step(); at_neg();
        check("rd_lat3", rsp_valid, 1'b1);
        check("rd_data", rsp_rdata, 36'h9ABCD1234);
        step(); at_neg();
        check("rd_popped", rsp_valid, 1'b0);

        // Backpressure: 8 reads with rsp_ready low
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        nxt       = 0;
        req_addr  = '0;
        for (int c = 0; c < 12; c++) begin
            at_neg();
            if (req_ready) nxt++;
            step();
            req_addr = AW'(nxt);
        end
        at_neg();
        check("bp_accepted", 64'(nxt), 64'd4);
        check("bp_ready_low", req_ready, 1'b0);
        check("bp_busy", busy, 1'b1);
        check("bp_head", rsp_rdata, 36'hC00000000);
        step();
        rsp_ready = 1'b1;
        base      = n_rsp;
        for (int c = 0; c < 60 && nxt < 8; c++) begin
            at_neg();
            if (req_ready) nxt++;
            step();
            req_addr = AW'(nxt);
            if (nxt == 8) req_valid = 1'b0;
        end
        check("bp_all_acc", 64'(nxt), 64'd8);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            at_neg();
            step();
        end
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_rsp_count", 64'(n_rsp - base), 64'd8);

        // Fill with zero
        step();
        init_start = 1'b1;
        init_value = '0;
        at_neg();
        check("fill_start_ready", req_ready, 1'b0);
        step();
        init_start = 1'b0;
        for (int c = 0; c <= 18; c++) begin
            at_neg();
            check("fill_ready", req_ready, c >= 16);
            check("fill_busy", busy, c < 16);
            check("fill_done", init_done, c == 17);
            if (c >= 1 && c <= 16)
                check("fill_port", {bram_en, bram_we, bram_addr, bram_din}, {2'b11, AW'(c - 1), 36'h0});
            else
                check("fill_en", bram_en, 1'b0);
            step();
        end
        read_check("post_fill", 4'h3, 36'h0);

        // init_start wins over a simultaneous read; second pulse mid-fill ignored
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 4'h7;
        init_start = 1'b1;
        init_value = 36'h012345678;
        at_neg();
        check("cf_first_ready", req_ready, 1'b0);
        step();
        init_start = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            at_neg();
            check("cf_ready", req_ready, c == 16);
            step();
            init_start = (c == 4);
            if (c == 4) init_value = 36'hFFFFFFFFF;
            if (c == 16) req_valid = 1'b0;
        end
        wait_rsp("cf_read", 36'h012345678);

        // Reset with three reads in flight
        req_valid = 1'b1;
        req_we    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr = AW'(i + 1);
            at_neg();
            check("rm_ready", req_ready, 1'b1);
            step();
        end
        req_valid = 1'b0;
        rstB      = 1'b1;
        step();
        rstB = 1'b0;
        for (int c = 0; c < 6; c++) begin
            at_neg();
            check("rm_rsp_valid", rsp_valid, 1'b0);
            check("rm_busy", busy, 1'b0);
            step();
        end
        read_check("post_rst", 4'h2, 36'h012345678);

        at_neg();
        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
